// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control encodings: reset level, per-stage stall vectors, EX op kinds.
package pipe_stall_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;

    // Bit i holds stage i: [0] pc [1] if_id [2] id_ex [3] ex_mem [4] mem_wb [5] reserved
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        EXOP_NONE = 2'b00,
        EXOP_MADD = 2'b01,
        EXOP_DIV  = 2'b10,
        EXOP_RSVD = 2'b11
    } exop_e;

    function automatic logic is_multi_cycle(input logic [1:0] kind);
        return (kind == EXOP_MADD) || (kind == EXOP_DIV);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges ID load-use, EX multi-cycle and flush requests
// into a per-stage stall vector, and times EX multi-cycle ops with a small FSM.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MADD_CYCLES = 2,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic [1:0]       ex_op_kind,
    input  logic             ex_cancel,
    input  logic             flush_req,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             ex_busy,
    output logic             ex_done,
    output logic [CNT_W-1:0] ex_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_last;
    logic [CNT_W-1:0] w_last_nxt;
    logic             w_req;

    assign w_req = is_multi_cycle(ex_op_kind);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // r_last keeps N-1 for the op in flight, so later kind changes cannot retime it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req && !flush_req) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_W'(1);
                    w_last_nxt  = (ex_op_kind == EXOP_MADD) ? CNT_W'(MADD_CYCLES - 1)
                                                             : CNT_W'(DIV_CYCLES - 1);
                end
            end
            ST_BUSY: begin
                if (flush_req || ex_cancel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == r_last) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ex_busy = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
        ex_done = (r_state == ST_DONE);
        flush   = flush_req;
        if (flush_req) begin
            stall = STALL_NONE;
        end else if (ex_busy) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end else begin
            stall = STALL_NONE;
        end
    end

    assign ex_cnt = r_cnt;

endmodule
